// File: rtl/lcd_hd44780_responder.sv
// HD44780-style character LCD responder: samples EN/RS/RW/data on EN falling edge,
// keeps a 2x16 character buffer, cursor, mode flags and a busy-time model.
module lcd_hd44780_responder #(
    parameter int unsigned BUSY_CMD   = 2000,
    parameter int unsigned BUSY_HOME  = 82000,
    parameter int unsigned BUSY_CLEAR = 82000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EN,
    input  logic        RS,
    input  logic        RW,
    input  logic [7:0]  data,
    input  logic [4:0]  rd_addr,
    output logic [7:0]  rd_char,
    output logic [6:0]  cursor_addr,
    output logic        busy,
    output logic        display_on,
    output logic        cursor_on,
    output logic        blink_on,
    output logic        two_line,
    output logic        entry_inc,
    output logic        overrun,
    output logic        addr_err,
    output logic [15:0] wr_count
);

    // Busy cycles left after the 32-cycle fill; zero means the fill alone covers Clear.
    localparam int unsigned CLEAR_TAIL = (BUSY_CLEAR > 32) ? (BUSY_CLEAR - 32) : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_CLEARING
    } state_t;

    typedef enum logic [3:0] {
        C_NOP,
        C_CLEAR,
        C_HOME,
        C_ENTRY,
        C_DISP,
        C_SHIFT,
        C_FUNC,
        C_CGRAM,
        C_DDRAM
    } cmd_t;

    state_t      state, state_nx;
    cmd_t        cmd;
    logic [31:0] cnt, cnt_nx;
    logic [4:0]  clr_idx, clr_idx_nx;
    logic        en_q;
    logic        xfer;
    logic        do_char;
    logic        do_cmd;
    logic        ddram_ok;
    logic        ovr_nx;
    logic        aerr_nx;
    logic [4:0]  wr_idx;
    logic [7:0]  mem [32];

    function automatic logic [6:0] step_cursor(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h0F) return 7'h40;
            if (a == 7'h4F) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00) return 7'h4F;
        if (a == 7'h40) return 7'h0F;
        return a - 7'd1;
    endfunction

    assign xfer     = en_q & ~EN;
    assign busy     = (state != S_IDLE);
    assign ddram_ok = (data[5:4] == 2'b00);
    assign wr_idx   = {cursor_addr[6], cursor_addr[3:0]};

    // Instruction class is chosen by the highest set bit of the byte.
    always_comb begin
        cmd = C_NOP;
        casez (data)
            8'b1???????: cmd = C_DDRAM;
            8'b01??????: cmd = C_CGRAM;
            8'b001?????: cmd = C_FUNC;
            8'b0001????: cmd = C_SHIFT;
            8'b00001???: cmd = C_DISP;
            8'b000001??: cmd = C_ENTRY;
            8'b0000001?: cmd = C_HOME;
            8'b00000001: cmd = C_CLEAR;
            default:     cmd = C_NOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_CLEARING;
            cnt     <= '0;
            clr_idx <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            clr_idx <= clr_idx_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        clr_idx_nx = clr_idx;
        do_char    = 1'b0;
        do_cmd     = 1'b0;
        ovr_nx     = 1'b0;
        aerr_nx    = 1'b0;
        case (state)
            S_IDLE: begin
                if (xfer && !RW) begin
                    if (RS) begin
                        do_char  = 1'b1;
                        state_nx = S_EXEC;
                        cnt_nx   = BUSY_CMD - 1;
                    end else begin
                        do_cmd = 1'b1;
                        case (cmd)
                            C_NOP: ;
                            C_CLEAR: begin
                                state_nx   = S_CLEARING;
                                clr_idx_nx = '0;
                            end
                            C_HOME: begin
                                state_nx = S_EXEC;
                                cnt_nx   = BUSY_HOME - 1;
                            end
                            default: begin
                                state_nx = S_EXEC;
                                cnt_nx   = BUSY_CMD - 1;
                                aerr_nx  = (cmd == C_DDRAM) && !ddram_ok;
                            end
                        endcase
                    end
                end
            end
            S_EXEC: begin
                ovr_nx = xfer;
                if (cnt == '0) state_nx = S_IDLE;
                else           cnt_nx   = cnt - 1;
            end
            S_CLEARING: begin
                ovr_nx = xfer;
                if (clr_idx == 5'd31) begin
                    if (CLEAR_TAIL == 0) begin
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_EXEC;
                        cnt_nx   = CLEAR_TAIL - 1;
                    end
                end else begin
                    clr_idx_nx = clr_idx + 5'd1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q        <= 1'b0;
            display_on  <= 1'b0;
            cursor_on   <= 1'b0;
            blink_on    <= 1'b0;
            two_line    <= 1'b0;
            entry_inc   <= 1'b1;
            cursor_addr <= '0;
            wr_count    <= '0;
            overrun     <= 1'b0;
            addr_err    <= 1'b0;
            rd_char     <= '0;
        end else begin
            en_q     <= EN;
            overrun  <= ovr_nx;
            addr_err <= aerr_nx;
            rd_char  <= mem[rd_addr];
            if (do_char) begin
                cursor_addr <= step_cursor(cursor_addr, entry_inc);
                wr_count    <= wr_count + 16'd1;
            end
            if (do_cmd) begin
                case (cmd)
                    C_CLEAR: begin
                        cursor_addr <= '0;
                        entry_inc   <= 1'b1;
                    end
                    C_HOME:  cursor_addr <= '0;
                    C_ENTRY: entry_inc <= data[1];
                    C_DISP: begin
                        display_on <= data[2];
                        cursor_on  <= data[1];
                        blink_on   <= data[0];
                    end
                    C_FUNC:  two_line <= data[3];
                    C_DDRAM: if (ddram_ok) cursor_addr <= data[6:0];
                    default: ;
                endcase
            end
        end
    end

    // Character buffer has no reset; the post-reset fill initialises it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEARING) mem[clr_idx] <= 8'h20;
            else if (do_char)        mem[wr_idx]  <= data;
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Scoreboard bench for lcd_hd44780_responder: directed bus transfers push expected
// observations into a queue; a monitor pops and compares as each probe returns.
module tb_lcd_hd44780_responder;

    localparam int unsigned T_CMD   = 8;
    localparam int unsigned T_HOME  = 20;
    localparam int unsigned T_CLEAR = 40;
    localparam int          LIMIT   = 200;

    localparam int K_RD   = 0;
    localparam int K_CUR  = 1;
    localparam int K_WRC  = 2;
    localparam int K_BUSY = 3;
    localparam int K_FLG  = 4;
    localparam int K_OVR  = 5;
    localparam int K_AERR = 6;
    localparam int K_BLEN = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        EN = 1'b0, RS = 1'b0, RW = 1'b0;
    logic [7:0]  data = '0;
    logic [4:0]  rd_addr = '0;
    logic [7:0]  rd_char;
    logic [6:0]  cursor_addr;
    logic        busy, display_on, cursor_on, blink_on, two_line, entry_inc;
    logic        overrun, addr_err;
    logic [15:0] wr_count;
    logic [4:0]  flags;

    typedef struct {
        int          kind;
        int          addr;
        logic [15:0] exp;
    } item_t;

    item_t       sb[$];
    int          checks = 0;
    int          failures = 0;
    logic        sample_req = 1'b0;
    logic        req_d = 1'b0;
    logic [15:0] ovr_cnt = '0;
    logic [15:0] aerr_cnt = '0;
    logic [15:0] run = '0;
    logic [15:0] last_len = '0;

    lcd_hd44780_responder #(
        .BUSY_CMD  (T_CMD),
        .BUSY_HOME (T_HOME),
        .BUSY_CLEAR(T_CLEAR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .EN         (EN),
        .RS         (RS),
        .RW         (RW),
        .data       (data),
        .rd_addr    (rd_addr),
        .rd_char    (rd_char),
        .cursor_addr(cursor_addr),
        .busy       (busy),
        .display_on (display_on),
        .cursor_on  (cursor_on),
        .blink_on   (blink_on),
        .two_line   (two_line),
        .entry_inc  (entry_inc),
        .overrun    (overrun),
        .addr_err   (addr_err),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    assign flags = {display_on, cursor_on, blink_on, two_line, entry_inc};

    // Pulse counters and busy-run length, taken from pre-edge values.
    always @(posedge clk) begin
        req_d <= sample_req;
        if (overrun)  ovr_cnt  <= ovr_cnt + 16'd1;
        if (addr_err) aerr_cnt <= aerr_cnt + 16'd1;
        if (rst) run <= '0;
        else if (busy) run <= run + 16'd1;
        else if (run != 0) begin
            last_len <= run;
            run      <= '0;
        end
    end

    function automatic string kname(input int k);
        case (k)
            K_RD:   return "rd_char";
            K_CUR:  return "cursor_addr";
            K_WRC:  return "wr_count";
            K_BUSY: return "busy";
            K_FLG:  return "flags";
            K_OVR:  return "overrun_pulses";
            K_AERR: return "addr_err_pulses";
            default: return "busy_len";
        endcase
    endfunction

    always @(negedge clk) begin
        if (req_d) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow got=probe exp=item");
            end else begin
                item_t       it;
                logic [15:0] act;
                it = sb.pop_front();
                case (it.kind)
                    K_RD:    act = {8'h00, rd_char};
                    K_CUR:   act = {9'h000, cursor_addr};
                    K_WRC:   act = wr_count;
                    K_BUSY:  act = {15'h0000, busy};
                    K_FLG:   act = {11'h000, flags};
                    K_OVR:   act = ovr_cnt;
                    K_AERR:  act = aerr_cnt;
                    default: act = last_len;
                endcase
                checks++;
                if (act !== it.exp) begin
                    failures++;
                    $display("FAIL %s[%0d] got=%0h exp=%0h t=%0t", kname(it.kind), it.addr, act, it.exp, $time);
                end
            end
        end
    end

    task automatic expect_item(input int kind, input int addr, input logic [15:0] exp);
        logic [31:0] a;
        a = addr;
        rd_addr = a[4:0];
        sb.push_back('{kind: kind, addr: addr, exp: exp});
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL wait_idle got=busy exp=idle within %0d cycles", LIMIT);
        end
    endtask

    task automatic pulse(input logic rs, input logic rw, input logic [7:0] d);
        RS = rs; RW = rw; data = d; EN = 1'b1;
        @(negedge clk);
        EN = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic rs, input logic [7:0] d);
        wait_idle();
        pulse(rs, 1'b0, d);
    endtask

    task automatic expect_blank_buffer();
        for (int i = 0; i < 32; i++) expect_item(K_RD, i, 16'h0020);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] s1 [5];
        logic [7:0] s2 [6];
        s1 = '{8'h43, 8'h4C, 8'h45, 8'h41, 8'h52};
        s2 = '{8'h2B, 8'h30, 8'h30, 8'h31, 8'h32, 8'h33};

        // Reset values, observed while reset is still held
        repeat (3) @(negedge clk);
        expect_item(K_RD, 5, 16'h0000);
        expect_item(K_CUR, 0, 16'h0000);
        expect_item(K_WRC, 0, 16'h0000);
        expect_item(K_FLG, 0, 16'h0001);
        expect_item(K_BUSY, 0, 16'h0001);
        @(negedge clk);
        rst = 1'b0;
        wait_idle();
        expect_item(K_BLEN, 0, 16'(T_CLEAR));
        expect_blank_buffer();
        expect_item(K_CUR, 0, 16'h0000);
        expect_item(K_FLG, 0, 16'h0001);

        // Init sequence and "CLEAR"
        send(1'b0, 8'h38);
        send(1'b0, 8'h0E);
        send(1'b0, 8'h01);
        wait_idle();
        expect_item(K_BLEN, 0, 16'(T_CLEAR));
        send(1'b0, 8'h02);
        wait_idle();
        expect_item(K_BLEN, 0, 16'(T_HOME));
        send(1'b0, 8'h06);
        for (int i = 0; i < 5; i++) send(1'b1, s1[i]);
        wait_idle();
        expect_item(K_BLEN, 0, 16'(T_CMD));
        for (int i = 0; i < 5; i++) expect_item(K_RD, i, {8'h00, s1[i]});
        expect_item(K_RD, 5, 16'h0020);
        expect_item(K_CUR, 0, 16'h0005);
        expect_item(K_WRC, 0, 16'd5);
        expect_item(K_FLG, 0, 16'h001B);

        // Line 2 text, then Home leaves buffer intact
        send(1'b0, 8'hC0);
        for (int i = 0; i < 6; i++) send(1'b1, s2[i]);
        wait_idle();
        for (int i = 0; i < 6; i++) expect_item(K_RD, 16 + i, {8'h00, s2[i]});
        expect_item(K_CUR, 0, 16'h0046);
        expect_item(K_WRC, 0, 16'd11);
        send(1'b0, 8'h02);
        wait_idle();
        expect_item(K_CUR, 0, 16'h0000);
        expect_item(K_RD, 21, 16'h0033);

        // Window wrap on increment
        send(1'b0, 8'h8F);
        send(1'b1, 8'h41);
        wait_idle();
        expect_item(K_RD, 15, 16'h0041);
        expect_item(K_CUR, 0, 16'h0040);
        send(1'b0, 8'hCF);
        send(1'b1, 8'h42);
        wait_idle();
        expect_item(K_RD, 31, 16'h0042);
        expect_item(K_CUR, 0, 16'h0000);
        expect_item(K_WRC, 0, 16'd13);

        // Window wrap on decrement
        send(1'b0, 8'h04);
        wait_idle();
        expect_item(K_FLG, 0, 16'h001A);
        send(1'b1, 8'h58);
        wait_idle();
        expect_item(K_RD, 0, 16'h0058);
        expect_item(K_CUR, 0, 16'h004F);
        send(1'b1, 8'h59);
        send(1'b0, 8'hC0);
        send(1'b1, 8'h5A);
        wait_idle();
        expect_item(K_RD, 31, 16'h0059);
        expect_item(K_RD, 16, 16'h005A);
        expect_item(K_CUR, 0, 16'h000F);
        expect_item(K_WRC, 0, 16'd16);
        send(1'b0, 8'h06);

        // Second char one cycle after the first is discarded
        send(1'b1, 8'h61);
        pulse(1'b1, 1'b0, 8'h62);
        wait_idle();
        expect_item(K_OVR, 0, 16'd1);
        expect_item(K_RD, 15, 16'h0061);
        expect_item(K_RD, 16, 16'h005A);
        expect_item(K_CUR, 0, 16'h0040);
        expect_item(K_WRC, 0, 16'd17);

        // Invalid DDRAM addresses, display control, read and zero byte
        send(1'b0, 8'h90);
        wait_idle();
        expect_item(K_AERR, 0, 16'd1);
        expect_item(K_CUR, 0, 16'h0040);
        expect_item(K_BLEN, 0, 16'(T_CMD));
        send(1'b0, 8'hE7);
        send(1'b0, 8'h0D);
        wait_idle();
        expect_item(K_AERR, 0, 16'd2);
        expect_item(K_FLG, 0, 16'h0017);
        pulse(1'b0, 1'b1, 8'h01);
        expect_item(K_BUSY, 0, 16'h0000);
        pulse(1'b0, 1'b0, 8'h00);
        expect_item(K_BUSY, 0, 16'h0000);
        expect_item(K_WRC, 0, 16'd17);
        expect_item(K_CUR, 0, 16'h0040);
        expect_item(K_OVR, 0, 16'd1);

        // Read-before-write on the same index
        send(1'b0, 8'h81);
        wait_idle();
        rd_addr = 5'd1;
        RS = 1'b1; RW = 1'b0; data = 8'h4D; EN = 1'b1;
        @(negedge clk);
        EN = 1'b0;
        expect_item(K_RD, 1, 16'h004C);
        expect_item(K_RD, 1, 16'h004D);
        wait_idle();
        expect_item(K_CUR, 0, 16'h0002);
        expect_item(K_WRC, 0, 16'd18);

        // Reset in the middle of a Clear restarts the fill
        send(1'b0, 8'h01);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_idle();
        expect_item(K_BLEN, 0, 16'(T_CLEAR));
        expect_item(K_CUR, 0, 16'h0000);
        expect_item(K_WRC, 0, 16'd0);
        expect_item(K_FLG, 0, 16'h0001);
        expect_blank_buffer();
        expect_item(K_AERR, 0, 16'd2);

        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
